circuit_lut_gate: RTL and testbench
===================================

# circuit_lut_gate

Parametrised, registered successor to the fixed four-input gated boolean circuit. It evaluates a run-time programmable N_IN-input truth table on a valid/ready input stream. The result is ANDed with a selectable gate input, as the fixed design gates with its D input. It also counts gated hits and sits between stimulus sources and result sinks in the lab datapath.

## Interface
- N_IN, 4: number of function inputs; table width TBL_W = 2**N_IN; legal range 2..6
- GATE_BIT, N_IN-1: index of the IN_DATA bit that gates the output
- CNT_W, 8: width of the hit counter
- CLK  in  1  sole clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CFG_LOAD  in  1  shift-enable for truth-table loading
- CFG_BIT  in  1  serial table bit, MSB (entry TBL_W-1) first
- CFG_DONE  out  1  table fully loaded, block in RUN
- IN_VALID  in  1  input word valid
- IN_DATA  in  N_IN  input vector; bit i = function input i
- IN_READY  out  1  block accepts IN_DATA this cycle
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  sink accepts result
- OUT_F  out  1  gated result = IN_DATA[GATE_BIT] & table[IN_DATA]
- OUT_RAW  out  1  ungated table[IN_DATA]
- HIT_CNT  out  CNT_W  count of transferred results with OUT_F=1
- CNT_CLR  in  1  synchronous clear of HIT_CNT

## Operation
- States: UNCFG, LOADING, RUN.
- RST: state UNCFG, table 0, bit counter 0, CFG_DONE 0, IN_READY 0, OUT_VALID 0, OUT_F 0, OUT_RAW 0, HIT_CNT 0.
- UNCFG/RUN -> LOADING when CFG_LOAD=1. The first shift happens in that same cycle, and the bit counter restarts at 0.
- LOADING, CFG_LOAD=1: table <= {table[TBL_W-2:0], CFG_BIT}, counter+1. The shift that makes the count TBL_W moves the state to RUN and sets CFG_DONE=1 on the next edge.
- LOADING, CFG_LOAD=0 before TBL_W shifts: abort to UNCFG. The partial table is retained but unused, and CFG_DONE stays 0.
- CFG_DONE falls in the cycle LOADING is entered.
- IN_READY = (state==RUN) & (!OUT_VALID | OUT_READY). It is combinational and is 0 in UNCFG/LOADING.
- On an IN_VALID & IN_READY transfer, register OUT_RAW, OUT_F and OUT_VALID=1. Otherwise, if OUT_READY, OUT_VALID <= 0.
- A pending output survives entry to LOADING and drains normally. Its value is not recomputed with the new table.
- HIT_CNT: +1 on each OUT_VALID & OUT_READY with OUT_F=1. Saturates at 2**CNT_W-1.
- If CNT_CLR and a hit occur together, CNT_CLR wins and HIT_CNT = 0.

## Timing
- Input-to-output latency is 1 cycle. Throughput is 1 result/cycle while OUT_READY=1.
- OUT_* are held stable while OUT_VALID=1 and OUT_READY=0.
- A full table load takes TBL_W cycles of CFG_LOAD=1. IN_READY can first be 1 on the cycle after the last shift.
- RST asserted mid-load or mid-stream clears everything immediately, with no completion of the in-flight transfer.
- The hit counter updates on the edge after the transfer.

## Structure
- Package circuit_lut_pkg holds:
  - the state enum (UNCFG, LOADING, RUN);
  - the function TBL_W(n) = 2**n;
  - a localparam for the counter saturation value.
- Sub-module circuit_lut_cfg holds the shift register, bit counter and state FSM. It exports the table and CFG_DONE.
- The top level holds the output register, handshake and hit counter.

## Test plan
- Reset then load 16'h8000 (AND4) MSB first, 16 cycles:
  - CFG_DONE=1 on cycle 17.
  - IN_DATA=4'hF gives OUT_RAW=1, OUT_F=1.
  - IN_DATA=4'h7 gives OUT_RAW=0, OUT_F=0.
- Load 16'hFFFF and stream 0..15 with OUT_READY=1:
  - OUT_RAW is always 1.
  - OUT_F=1 only for 8..F.
  - HIT_CNT=8.
- Backpressure:
  - With OUT_READY=0 for 3 cycles after the first result, IN_READY=0 and OUT_* hold.
  - Releasing OUT_READY resumes with no loss or duplicate.
- Abort load:
  - CFG_LOAD low after 5 bits gives state UNCFG, CFG_DONE=0 and IN_READY=0.
  - A full reload then works.
- With CNT_W=2, 5 hits leave HIT_CNT=3. CNT_CLR coincident with a hit gives HIT_CNT=0.
- RST pulse mid-stream with OUT_VALID=1 gives all outputs 0 and HIT_CNT 0. CFG_DONE=0 until reload.

Source files
------------

// File: rtl/circuit_lut_pkg.sv
// Shared types and helpers for the programmable gated truth-table block.
package circuit_lut_pkg;

    typedef enum logic [1:0] {
        UNCFG   = 2'd0,
        LOADING = 2'd1,
        RUN     = 2'd2
    } lut_state_e;

    function automatic int unsigned tbl_w(input int unsigned n);
        return 32'd1 << n;
    endfunction

    localparam int unsigned HIT_CNT_W_DEF = 8;

    // Widest supported saturation pattern; users slice it to their counter width.
    localparam logic [63:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/circuit_lut_cfg.sv
// Serial truth-table loader: MSB-first shift register, bit counter and
// UNCFG/LOADING/RUN sequencing.
module circuit_lut_cfg
    import circuit_lut_pkg::*;
#(
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned TBL_W = tbl_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic             cfg_bit,
    output logic [TBL_W-1:0] tbl,
    output logic             cfg_done,
    output lut_state_e       state
);

    localparam int unsigned CNT_BW = N_IN + 1;
    localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(TBL_W);

    lut_state_e        state_q, state_d;
    logic [TBL_W-1:0]  tbl_q, tbl_d;
    logic [CNT_BW-1:0] bit_cnt_q, bit_cnt_d;
    logic              cfg_done_q, cfg_done_d;

    always_comb begin
        state_d    = state_q;
        tbl_d      = tbl_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_done_d = cfg_done_q;
        unique case (state_q)
            UNCFG, RUN: begin
                // Entering a load shifts the first bit in the same cycle.
                if (cfg_load) begin
                    tbl_d      = {tbl_q[TBL_W-2:0], cfg_bit};
                    bit_cnt_d  = CNT_BW'(1);
                    state_d    = LOADING;
                    cfg_done_d = 1'b0;
                end
            end
            LOADING: begin
                if (cfg_load) begin
                    tbl_d     = {tbl_q[TBL_W-2:0], cfg_bit};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == LAST_CNT) begin
                        state_d    = RUN;
                        cfg_done_d = 1'b1;
                    end
                end else begin
                    state_d    = UNCFG;
                    cfg_done_d = 1'b0;
                end
            end
            default: begin
                state_d    = UNCFG;
                cfg_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= UNCFG;
            tbl_q      <= '0;
            bit_cnt_q  <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tbl_q      <= tbl_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_done_q <= cfg_done_d;
        end
    end

    assign tbl      = tbl_q;
    assign cfg_done = cfg_done_q;
    assign state    = state_q;

endmodule

// File: rtl/circuit_lut_gate.sv
// Registered N_IN-input programmable truth table on a valid/ready stream,
// gated by one input bit, with a saturating hit counter.
module circuit_lut_gate
    import circuit_lut_pkg::*;
#(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned GATE_BIT = N_IN - 1,
    parameter int unsigned CNT_W    = HIT_CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_LOAD,
    input  logic             CFG_BIT,
    output logic             CFG_DONE,
    input  logic             IN_VALID,
    input  logic [N_IN-1:0]  IN_DATA,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_F,
    output logic             OUT_RAW,
    output logic [CNT_W-1:0] HIT_CNT,
    input  logic             CNT_CLR
);

    localparam int unsigned TBL_W = tbl_w(N_IN);
    localparam logic [CNT_W-1:0] HIT_SAT = CNT_SAT_ALL[CNT_W-1:0];

    logic [TBL_W-1:0] tbl;
    lut_state_e       state;

    circuit_lut_cfg #(
        .N_IN (N_IN)
    ) u_cfg (
        .clk      (CLK),
        .rst      (RST),
        .cfg_load (CFG_LOAD),
        .cfg_bit  (CFG_BIT),
        .tbl      (tbl),
        .cfg_done (CFG_DONE),
        .state    (state)
    );

    logic             out_valid_q, out_valid_d;
    logic             out_f_q, out_f_d;
    logic             out_raw_q, out_raw_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             in_fire;
    logic             raw_bit;

    assign IN_READY = (state == RUN) && (!out_valid_q || OUT_READY);
    assign in_fire  = IN_VALID && IN_READY;
    assign raw_bit  = tbl[IN_DATA];

    always_comb begin
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        out_raw_d   = out_raw_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_raw_d   = raw_bit;
            out_f_d     = IN_DATA[GATE_BIT] & raw_bit;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear takes priority over a coincident hit.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (CNT_CLR) begin
            hit_cnt_d = '0;
        end else if (out_valid_q && OUT_READY && out_f_q && (hit_cnt_q != HIT_SAT)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_f_q     <= 1'b0;
            out_raw_q   <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_raw_q   <= out_raw_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_F     = out_f_q;
    assign OUT_RAW   = out_raw_q;
    assign HIT_CNT   = hit_cnt_q;

endmodule

// File: tb/tb_circuit_lut_gate.sv
// Scoreboard bench for circuit_lut_gate: stimulus pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_circuit_lut_gate;

    localparam int unsigned N_IN     = 4;
    localparam int unsigned GATE_BIT = 3;
    localparam int unsigned TBL_W    = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned CNT_W2   = 2;
    localparam int unsigned SAT1     = 255;
    localparam int unsigned SAT2     = 3;

    logic clk = 1'b0;
    logic rst, cfg_load, cfg_bit, in_valid, out_ready, cnt_clr;
    logic [N_IN-1:0] in_data;

    logic cfg_done, in_ready, out_valid, out_f, out_raw;
    logic [CNT_W-1:0] hit_cnt;
    logic cfg_done2, in_ready2, out_valid2, out_f2, out_raw2;
    logic [CNT_W2-1:0] hit_cnt2;

    always #5 clk = ~clk;

    circuit_lut_gate #(.N_IN(N_IN), .GATE_BIT(GATE_BIT), .CNT_W(CNT_W)) u_dut (
        .CLK(clk), .RST(rst), .CFG_LOAD(cfg_load), .CFG_BIT(cfg_bit), .CFG_DONE(cfg_done),
        .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_F(out_f), .OUT_RAW(out_raw),
        .HIT_CNT(hit_cnt), .CNT_CLR(cnt_clr)
    );

    circuit_lut_gate #(.N_IN(N_IN), .GATE_BIT(GATE_BIT), .CNT_W(CNT_W2)) u_dut2 (
        .CLK(clk), .RST(rst), .CFG_LOAD(cfg_load), .CFG_BIT(cfg_bit), .CFG_DONE(cfg_done2),
        .IN_VALID(in_valid), .IN_DATA(in_data), .IN_READY(in_ready2),
        .OUT_VALID(out_valid2), .OUT_READY(out_ready), .OUT_F(out_f2), .OUT_RAW(out_raw2),
        .HIT_CNT(hit_cnt2), .CNT_CLR(cnt_clr)
    );

    typedef struct {
        logic raw;
        logic f;
    } exp_t;

    exp_t             exp_q[$];
    logic [TBL_W-1:0] model_tbl = '0;
    int unsigned      hit_m  = 0;
    int unsigned      hit_m2 = 0;
    int               checks   = 0;
    int               failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: output is the addressed table entry, gated by the selected input bit.
    function automatic exp_t ref_eval(input logic [N_IN-1:0] d);
        exp_t r;
        r.raw = model_tbl[d];
        r.f   = d[GATE_BIT] & r.raw;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic hit;
        if (!rst) begin
            check("hit_cnt", 32'(hit_cnt), hit_m);
            check("hit_cnt_w2", 32'(hit_cnt2), hit_m2);
            hit = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=valid required=no_output at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_raw", 32'(out_raw), 32'(e.raw));
                    check("out_f", 32'(out_f), 32'(e.f));
                    check("dut2_out_f", 32'(out_f2), 32'(e.f));
                    hit = e.f;
                end
            end
            if (cnt_clr) begin
                hit_m  = 0;
                hit_m2 = 0;
            end else if (hit) begin
                if (hit_m < SAT1) hit_m++;
                if (hit_m2 < SAT2) hit_m2++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [TBL_W-1:0] t, input int unsigned nbits);
        cfg_load = 1'b1;
        for (int unsigned i = 0; i < nbits; i++) begin
            cfg_bit = t[TBL_W-1-i];
            step();
            check("cfg_done_during_load", 32'(cfg_done), 32'(i + 1 == TBL_W));
        end
        cfg_load = 1'b0;
        cfg_bit  = 1'b0;
        if (nbits == TBL_W) model_tbl = t;
    endtask

    task automatic send(input logic [N_IN-1:0] d);
        int unsigned budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && budget < 50) begin
            step();
            #1;
            budget++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high data=%0h", d);
        end else begin
            exp_q.push_back(ref_eval(d));
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic random_stream(input int unsigned ncyc);
        for (int unsigned c = 0; c < ncyc; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_data   = N_IN'($urandom);
            out_ready = ($urandom % 4) != 0;
            cnt_clr   = ($urandom % 64) == 0;
            #1;
            if (in_valid && in_ready) exp_q.push_back(ref_eval(in_data));
            step();
        end
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_bit = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #3;
        check("rst_cfg_done", 32'(cfg_done), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_f", 32'(out_f), 0);
        check("rst_out_raw", 32'(out_raw), 0);
        check("rst_hit_cnt", 32'(hit_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // AND4 table
        load(16'h8000, TBL_W);
        out_ready = 1'b1;
        send(4'hF);
        send(4'h7);
        drain();

        // All-ones table, 0..15; gate bit limits hits to 8..F
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        load(16'hFFFF, TBL_W);
        out_ready = 1'b1;
        for (int unsigned d = 0; d < 16; d++) send(N_IN'(d));
        drain();
        check("hit_cnt_all_ones", 32'(hit_cnt), 8);
        check("hit_cnt_w2_sat", 32'(hit_cnt2), 3);

        // Clear coincident with a hit
        send(4'hF);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        check("clr_wins_hit", 32'(hit_cnt), 0);
        check("clr_wins_hit_w2", 32'(hit_cnt2), 0);
        drain();

        // Backpressure: hold first result for 3 cycles
        load(16'hA5C3, TBL_W);
        out_ready = 1'b0;
        send(4'hB);
        in_valid = 1'b1;
        in_data  = 4'h5;
        for (int unsigned k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            if (exp_q.size() > 0) begin
                check("bp_hold_raw", 32'(out_raw), 32'(exp_q[0].raw));
                check("bp_hold_f", 32'(out_f), 32'(exp_q[0].f));
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(4'h5);
        send(4'hE);
        send(4'h9);
        drain();

        // Abort after 5 bits, then full reload
        load(16'h1234, 5);
        in_valid = 1'b1;
        step();
        check("abort_cfg_done", 32'(cfg_done), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        load(TBL_W'($urandom), TBL_W);
        random_stream(300);
        drain();

        // Reset mid-stream with a pending output
        out_ready = 1'b0;
        send(4'hF);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_f", 32'(out_f), 0);
        check("mid_rst_out_raw", 32'(out_raw), 0);
        check("mid_rst_hit_cnt", 32'(hit_cnt), 0);
        check("mid_rst_cfg_done", 32'(cfg_done), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        hit_m  = 0;
        hit_m2 = 0;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (3) step();
        check("post_rst_cfg_done", 32'(cfg_done), 0);
        check("post_rst_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        load(TBL_W'($urandom), TBL_W);
        random_stream(300);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
